// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: a DEPTH x WIDTH RAM read asynchronously at the
// read pointer, so the head entry is always visible on data_o. Pointers carry
// one extra wrap bit to tell full from empty. All outputs are decoded from the
// registered pointers and the RAM; push_i/pop_i never reach an output directly.
// DEPTH must be a power of two >= 2.
module fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_push_i,
    input  logic                     clk_pop_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // clk_pop_i shares the net with clk_push_i; it is kept only so the port
    // list matches the dual-clock variant and drives nothing.
    logic unused_clk_pop;
    assign unused_clk_pop = clk_pop_i;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrptr = '0;
    logic [PW-1:0]    rdptr = '0;

    logic push_ok;
    logic pop_ok;

    // Status decode from pointers only.
    always_comb begin
        usage_o = wrptr - rdptr;
        empty_o = (wrptr == rdptr);
        full_o  = (wrptr[AW-1:0] == rdptr[AW-1:0]) && (wrptr[AW] != rdptr[AW]);
        data_o  = mem[rdptr[AW-1:0]];
    end

    // Accept logic: a pop frees the slot a simultaneous push needs when full.
    always_comb begin
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full_o || pop_ok);
    end

    // Pointer registers; reset wins over any push/pop in the same cycle.
    always_ff @(posedge clk_push_i) begin
        if (rst_i) begin
            wrptr <= '0;
            rdptr <= '0;
        end else begin
            if (push_ok) wrptr <= wrptr + 1'b1;
            if (pop_ok)  rdptr <= rdptr + 1'b1;
        end
    end

    // RAM write port; contents survive reset, but a push during reset is dropped.
    always_ff @(posedge clk_push_i) begin
        if (push_ok && !rst_i) mem[wrptr[AW-1:0]] <= data_i;
    end

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft (DEPTH=2, WIDTH=32): a table of single-cycle
// vectors with hand-computed expectations, then a wrap-around streaming run
// checked against a small queue model.
module tb_fifo_fwft;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] dout;
    logic [1:0]       usage;

    int n_vec  = 0;
    int n_fail = 0;

    fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_push_i (clk),
        .clk_pop_i  (clk),
        .rst_i      (rst),
        .push_i     (push),
        .data_i     (din),
        .full_o     (full),
        .pop_i      (pop),
        .data_o     (dout),
        .empty_o    (empty),
        .usage_o    (usage)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        push;
        logic        pop;
        logic [31:0] din;
        logic [1:0]  usage;
        logic        empty;
        logic        full;
        logic        cd;
        logic [31:0] dout;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic r, input logic pu, input logic po,
                                input logic [31:0] d, input logic [1:0] u,
                                input logic e, input logic f, input logic cd,
                                input logic [31:0] q);
        vec_t v;
        v.rst = r; v.push = pu; v.pop = po; v.din = d; v.usage = u;
        v.empty = e; v.full = f; v.cd = cd; v.dout = q;
        return v;
    endfunction

    task automatic check(input string name, input logic [1:0] u, input logic e,
                         input logic f, input logic cd, input logic [31:0] q);
        n_vec++;
        if (usage !== u || empty !== e || full !== f || (cd && dout !== q)) begin
            n_fail++;
            $display("FAIL %s: usage=%0d empty=%0b full=%0b data=%h, want usage=%0d empty=%0b full=%0b data=%h%s",
                     name, usage, empty, full, dout, u, e, f, q, cd ? "" : "(data unchecked)");
        end
    endtask

    task automatic step(input logic r, input logic pu, input logic po, input logic [31:0] d);
        rst = r; push = pu; pop = po; din = d;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] head;

    initial begin
        //           rst push pop din           usage empty full cd  dout
        vt[0]  = mk(1, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0);          // reset beats push
        vt[1]  = mk(0, 0, 0, 32'h0,         0, 1, 0, 0, 32'h0);          // idle after reset
        vt[2]  = mk(0, 1, 0, 32'hA5A5_A5A5, 1, 0, 0, 1, 32'hA5A5_A5A5);  // fall-through
        vt[3]  = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 32'h0);
        vt[4]  = mk(0, 1, 0, 32'h11,        1, 0, 0, 1, 32'h11);
        vt[5]  = mk(0, 1, 0, 32'h22,        2, 0, 1, 1, 32'h11);          // full
        vt[6]  = mk(0, 1, 0, 32'h33,        2, 0, 1, 1, 32'h11);          // push on full ignored
        vt[7]  = mk(0, 0, 1, 32'h0,         1, 0, 0, 1, 32'h22);
        vt[8]  = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 32'h0);
        vt[9]  = mk(0, 1, 0, 32'h11,        1, 0, 0, 1, 32'h11);
        vt[10] = mk(0, 1, 0, 32'h22,        2, 0, 1, 1, 32'h11);
        vt[11] = mk(0, 1, 1, 32'h44,        2, 0, 1, 1, 32'h22);          // push+pop when full
        vt[12] = mk(0, 0, 1, 32'h0,         1, 0, 0, 1, 32'h44);
        vt[13] = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 32'h0);
        vt[14] = mk(0, 1, 1, 32'h55,        1, 0, 0, 1, 32'h55);          // pop on empty + push
        vt[15] = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 32'h0);
        vt[16] = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 32'h0);           // pop on empty ignored
        vt[17] = mk(0, 1, 0, 32'h66,        1, 0, 0, 1, 32'h66);
        vt[18] = mk(0, 1, 0, 32'h77,        2, 0, 1, 1, 32'h66);
        vt[19] = mk(1, 1, 0, 32'h88,        0, 1, 0, 0, 32'h0);           // reset with 2 entries
        vt[20] = mk(0, 1, 0, 32'h99,        1, 0, 0, 1, 32'h99);
        vt[21] = mk(0, 0, 1, 32'h0,         0, 1, 0, 0, 32'h0);

        // Power-up state before any clock edge.
        #1;
        check("powerup", 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].push, vt[i].pop, vt[i].din);
            check($sformatf("vec%0d", i), vt[i].usage, vt[i].empty, vt[i].full,
                  vt[i].cd, vt[i].dout);
        end

        // Streaming across pointer wrap-around: keep the FIFO full and do ten
        // simultaneous push/pop pairs, then drain; order must match the queue.
        q.delete();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h100 + i);
            q.push_back(32'h100 + i);
            check($sformatf("fill%0d", i), 2'(q.size()), 1'b0, q.size() == 2, 1'b1, q[0]);
        end
        for (int i = 2; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'h100 + i);
            void'(q.pop_front());
            q.push_back(32'h100 + i);
            check($sformatf("wrap%0d", i), 2'd2, 1'b0, 1'b1, 1'b1, q[0]);
        end
        while (q.size() > 0) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            void'(q.pop_front());
            head = (q.size() > 0) ? q[0] : 32'h0;
            check($sformatf("drain%0d", q.size()), 2'(q.size()), q.size() == 0, 1'b0,
                  q.size() > 0, head);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_fwft.md
FIFO_FWFT -- requirements
Module: fifo_fwft

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the entry data width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning the entry count; it SHALL be a power of two >= 2.
REQ-003 The module SHALL have port clk_push_i, input, 1 bit: the single clock. All registers are clocked on its rising edge.
REQ-004 The module SHALL have port clk_pop_i, input, 1 bit: driven by the same clock net as clk_push_i. It exists for port compatibility only. The design has one clock domain and no CDC logic.
REQ-005 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port push_i, input, 1 bit: write request.
REQ-007 The module SHALL have port data_i, input, WIDTH bits: write data.
REQ-008 The module SHALL have port full_o, output, 1 bit: FIFO holds DEPTH entries.
REQ-009 The module SHALL have port pop_i, input, 1 bit: consume the head entry.
REQ-010 The module SHALL have port data_o, output, WIDTH bits: head entry, first-word-fall-through.
REQ-011 The module SHALL have port empty_o, output, 1 bit: FIFO holds 0 entries.
REQ-012 The module SHALL have port usage_o, output, clog2(DEPTH)+1 bits: current entry count, 0..DEPTH.

Function
REQ-013 Storage SHALL be a DEPTH x WIDTH dual-port RAM. The write port is indexed by the write pointer. The read port is indexed by the read pointer and SHALL be read combinationally (asynchronously).
REQ-014 The read and write pointers SHALL each be clog2(DEPTH)+1 bits. The low clog2(DEPTH) bits index the RAM. The MSB is a wrap bit.
REQ-015 usage_o SHALL equal (wrptr - rdptr) modulo 2^(clog2(DEPTH)+1), purely combinational from the pointers.
REQ-016 empty_o SHALL be 1 iff wrptr == rdptr.
REQ-017 full_o SHALL be 1 iff the index bits are equal and the wrap bits differ, i.e. usage_o == DEPTH.
REQ-018 A push SHALL be accepted at a rising edge when push_i=1 and either full_o=0 or a pop is accepted at the same edge.
- An accepted push writes data_i to RAM[wrptr index] and increments wrptr.
REQ-019 A pop SHALL be accepted at a rising edge when pop_i=1 and empty_o=0; it increments rdptr.
- Popping discards the head entry; data_o then shows the next entry combinationally.
REQ-020 data_o SHALL always equal RAM[rdptr index]. When empty_o=1 its value is don't-care and SHALL NOT be relied on.
REQ-021 First-word-fall-through: a word pushed into an empty FIFO SHALL appear on data_o, with empty_o=0, in the cycle immediately after the push edge, without any pop.
REQ-022 push_i while full with no accepted pop SHALL be ignored: no RAM write, no state change.
REQ-023 pop_i while empty SHALL be ignored, including when push_i=1 in the same cycle. In that case the push is accepted and usage becomes 1.
REQ-024 Simultaneous accepted push and pop on a non-empty FIFO SHALL leave usage_o unchanged.
- This holds when full: the pushed data goes to the slot freed by the pop.
REQ-025 Pointers SHALL wrap naturally modulo 2^(clog2(DEPTH)+1). Ordering SHALL be strictly first-in-first-out across wrap-around.
REQ-026 All outputs SHALL be combinational functions of registered pointers and RAM. There SHALL be no combinational path from push_i or pop_i to any output.

Reset
REQ-027 When rst_i=1 at a rising edge, rdptr and wrptr SHALL both be set to 0.
- Outputs follow: usage_o=0, empty_o=1, full_o=0.
- Reset overrides push_i and pop_i in the same cycle.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 Registers SHALL have an initial value of 0 for simulation and FPGA power-up.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries within one cycle.

Verification
REQ-031 Reset, then idle: the bench SHALL check usage_o=0, empty_o=1, full_o=0.
REQ-032 With DEPTH=2, WIDTH=32, push 0xA5A5A5A5 into the empty FIFO. The bench SHALL check that the next cycle gives data_o=0xA5A5A5A5, empty_o=0, usage_o=1.
REQ-033 Push 0x11 then 0x22 (DEPTH=2) -> full_o=1, usage_o=2.
- A further push of 0x33 is ignored.
- Pop -> data_o=0x22, usage_o=1. Pop -> empty_o=1.
REQ-034 When full, assert push 0x44 and pop simultaneously -> usage_o stays 2.
- Subsequent pops return the older entry, then 0x44.
REQ-035 Run 10 push/pop pairs of incrementing values across wrap-around -> data_o order is exactly the push order.
- The bench SHALL also check that pop on empty with push=1 yields usage_o=1.
REQ-036 Assert rst_i with 2 entries and push_i=1 -> next cycle usage_o=0, empty_o=1.
